// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the uart transmit path and its arbiter:
//   - transmit arbiter FSM state encoding (2-bit)
//   - bit positions inside the 5-bit uart ctrl_word {NSB,NPB,POE,NDB2,NDB1}
//   - default 8N1 configuration word
//   - number of cycles to wait for tx_busy after a start before giving up
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_t;

    localparam int CTRL_NDB1 = 0;
    localparam int CTRL_NDB2 = 1;
    localparam int CTRL_POE  = 2;
    localparam int CTRL_NPB  = 3;
    localparam int CTRL_NSB  = 4;

    localparam logic [4:0] CFG_8N1  = 5'b01011;

    localparam logic [1:0] BUSY_TMO = 2'd3;

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Free-running 16x baud enable generator. The counter runs every clock and
// restarts when it reaches or passes baud_div, so the enable period is
// baud_div+1 cycles. A divisor change is picked up at the next compare; a
// smaller divisor than the current count simply ends the period at once.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   baud_div   in   enable period minus 1
//   baud16_en  out  registered one-cycle enable pulse
// -----------------------------------------------------------------------------
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] baud_div,
    output logic             baud16_en
);

    logic [DIV_W-1:0] cnt;
    logic             hit;

    assign hit = (cnt >= baud_div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            baud16_en <= 1'b0;
        end else begin
            baud16_en <= hit;
            cnt       <= hit ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart transmitter between N_REQ byte producers with round-robin
// arbitration, owns the uart configuration word and the 16x baud enable.
// A pending configuration change is applied only while the transmitter is
// idle and takes priority over a grant in that cycle.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   baud_div   in   baud16_en period minus 1
//   cfg_wr     in   one-cycle strobe, latches cfg_word as pending config
//   cfg_word   in   new config {NSB,NPB,POE,NDB2,NDB1}
//   req_valid  in   per-requester byte pending
//   req_data   in   requester i byte at [8i+7:8i]
//   req_ready  out  one-cycle pulse, byte of requester i accepted
//   grant_id   out  index of last/current granted requester
//   tx_data    out  byte to uart
//   tx_start   out  one-cycle start pulse to uart
//   tx_busy    in   uart transmitter busy
//   ctrl_word  out  uart configuration word
//   baud16_en  out  one-cycle 16x baud enable
//   tx_lost    out  one-cycle pulse, uart never went busy after a start
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int         N_REQ   = 4,
    parameter int         DIV_W   = 16,
    parameter logic [4:0] CFG_RST = CFG_8N1,
    localparam int        GID_W   = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DIV_W-1:0]   baud_div,
    input  logic               cfg_wr,
    input  logic [4:0]         cfg_word,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic [GID_W-1:0]   grant_id,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    input  logic               tx_busy,
    output logic [4:0]         ctrl_word,
    output logic               baud16_en,
    output logic               tx_lost
);

    tx_state_t        state, state_nxt;
    logic [GID_W-1:0] last_grant;
    logic [GID_W-1:0] gnt;
    logic [4:0]       cfg_shadow;
    logic             cfg_pend;
    logic [1:0]       tmo;
    logic             do_cfg;
    logic             do_grant;
    logic             do_lost;

    // Search starts just after the previous winner and wraps, so the last
    // winner has the lowest priority.
    function automatic logic [GID_W-1:0] rr_pick(
        input logic [N_REQ-1:0] valid,
        input logic [GID_W-1:0] last
    );
        logic [GID_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = int'(last) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && valid[idx]) begin
                pick  = GID_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    uart_baud_gen #(
        .DIV_W(DIV_W)
    ) u_baud_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .baud_div (baud_div),
        .baud16_en(baud16_en)
    );

    always_comb begin
        state_nxt = state;
        do_cfg    = 1'b0;
        do_grant  = 1'b0;
        do_lost   = 1'b0;
        gnt       = rr_pick(req_valid, last_grant);
        case (state)
            IDLE: begin
                // A busy transmitter here was started by someone else: hold off.
                if (!tx_busy) begin
                    if (cfg_pend) begin
                        do_cfg = 1'b1;
                    end else if (|req_valid) begin
                        do_grant  = 1'b1;
                        state_nxt = START;
                    end
                end
            end
            START:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (tmo == BUSY_TMO - 2'd1) begin
                    do_lost   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready  <= '0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            grant_id   <= '0;
            last_grant <= GID_W'(N_REQ - 1);
            ctrl_word  <= CFG_RST;
            tx_lost    <= 1'b0;
            cfg_pend   <= 1'b0;
            tmo        <= '0;
        end else begin
            req_ready <= do_grant ? (N_REQ'(1) << gnt) : '0;
            tx_start  <= do_grant;
            tx_lost   <= do_lost;
            if (do_grant) begin
                tx_data    <= req_data[8*int'(gnt) +: 8];
                grant_id   <= gnt;
                last_grant <= gnt;
            end
            tmo <= (state == WAIT_BUSY && !tx_busy) ? tmo + 2'd1 : '0;
            if (do_cfg) ctrl_word <= cfg_shadow;
            // A write landing on the apply cycle keeps the new value pending.
            if (cfg_wr)      cfg_pend <= 1'b1;
            else if (do_cfg) cfg_pend <= 1'b0;
        end
    end

    // Shadow is only consumed while cfg_pend is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (cfg_wr) cfg_shadow <= cfg_word;
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int BUSY_LEN = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] baud_div;
    logic        cfg_wr;
    logic [4:0]  cfg_word;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [1:0]  grant_id;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [4:0]  ctrl_word;
    logic        baud16_en;
    logic        tx_lost;

    logic        model_on;
    logic        model_busy;
    logic        man_busy;
    int          model_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] mask;
        logic [1:0] gid;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[12];

    assign tx_busy = model_on ? model_busy : man_busy;

    uart_tx_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .baud_div (baud_div),
        .cfg_wr   (cfg_wr),
        .cfg_word (cfg_word),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .grant_id (grant_id),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .ctrl_word(ctrl_word),
        .baud16_en(baud16_en),
        .tx_lost  (tx_lost)
    );

    always #5 clk = ~clk;

    // uart transmitter model: goes busy the cycle after it sees tx_start
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_busy <= 1'b0;
            model_cnt  <= 0;
        end else if (model_busy) begin
            if (model_cnt == 0) model_busy <= 1'b0;
            else                model_cnt  <= model_cnt - 1;
        end else if (model_on && tx_start) begin
            model_busy <= 1'b1;
            model_cnt  <= BUSY_LEN - 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_start(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({name, "_start_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_busy(input logic lvl);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (tx_busy === lvl) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("busy_timeout", 32'(tx_busy), 32'(lvl));
    endtask

    task automatic wait_frame_done();
        wait_busy(1'b1);
        wait_busy(1'b0);
        @(negedge clk);
    endtask

    task automatic grant_check(input string name, input logic [3:0] mask,
                               input logic [1:0] gid, input logic [7:0] data);
        bit ok;
        req_valid = mask;
        wait_start(name, ok);
        if (ok) begin
            chk({name, "_gid"}, 32'(grant_id), 32'(gid));
            chk({name, "_data"}, 32'(tx_data), 32'(data));
            chk({name, "_ready"}, 32'(req_ready), 32'(4'b0001 << gid));
            req_valid = 4'b0000;
            @(negedge clk);
            chk({name, "_start_drop"}, {31'd0, tx_start}, 32'd0);
            chk({name, "_ready_drop"}, 32'(req_ready), 32'd0);
        end
        req_valid = 4'b0000;
    endtask

    task automatic reset_values(input string name);
        chk({name, "_ready"}, 32'(req_ready), 32'd0);
        chk({name, "_start"}, {31'd0, tx_start}, 32'd0);
        chk({name, "_data"}, 32'(tx_data), 32'd0);
        chk({name, "_gid"}, 32'(grant_id), 32'd0);
        chk({name, "_ctrl"}, 32'(ctrl_word), 32'h0b);
        chk({name, "_baud"}, {31'd0, baud16_en}, 32'd0);
        chk({name, "_lost"}, {31'd0, tx_lost}, 32'd0);
    endtask

    initial begin
        bit ok;

        vecs[0]  = '{4'b1111, 2'd0, 8'h5A};
        vecs[1]  = '{4'b1111, 2'd1, 8'hC3};
        vecs[2]  = '{4'b1111, 2'd2, 8'h0F};
        vecs[3]  = '{4'b1111, 2'd3, 8'hF0};
        vecs[4]  = '{4'b1111, 2'd0, 8'h5A};
        vecs[5]  = '{4'b0100, 2'd2, 8'h0F};
        vecs[6]  = '{4'b0101, 2'd0, 8'h5A};
        vecs[7]  = '{4'b0101, 2'd2, 8'h0F};
        vecs[8]  = '{4'b0010, 2'd1, 8'hC3};
        vecs[9]  = '{4'b0010, 2'd1, 8'hC3};
        vecs[10] = '{4'b1000, 2'd3, 8'hF0};
        vecs[11] = '{4'b1001, 2'd0, 8'h5A};

        rst_n     = 1'b0;
        baud_div  = 16'd3;
        cfg_wr    = 1'b0;
        cfg_word  = 5'b00000;
        req_valid = 4'b0000;
        req_data  = {8'hF0, 8'h0F, 8'hC3, 8'h5A};
        model_on  = 1'b1;
        man_busy  = 1'b0;

        repeat (3) @(negedge clk);
        reset_values("rst0");
        rst_n = 1'b1;

        // baud enable: divisor 3 -> every 4th cycle, divisor 0 -> every cycle
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (baud16_en) begin
                ok = 1'b1;
                break;
            end
        end
        chk("baud3_first", {31'd0, ok}, 32'd1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("baud3_c%0d", k), {31'd0, baud16_en}, {31'd0, (k % 4) == 0});
        end
        baud_div = 16'd0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("baud0_c%0d", k), {31'd0, baud16_en}, 32'd1);
        end
        baud_div = 16'd3;

        // round-robin and fairness vectors
        for (int v = 0; v < 12; v++) begin
            grant_check($sformatf("rr%0d", v), vecs[v].mask, vecs[v].gid, vecs[v].data);
            wait_frame_done();
        end

        // config write during WAIT_DONE: held until idle, then applied before the grant
        req_valid = 4'b0001;
        wait_start("cfg_pre", ok);
        chk("cfg_pre_gid", 32'(grant_id), 32'd0);
        req_valid = 4'b0110;
        wait_busy(1'b1);
        repeat (3) @(negedge clk);
        cfg_word = 5'b00111;
        cfg_wr   = 1'b1;
        @(negedge clk);
        cfg_wr   = 1'b0;
        chk("cfg_hold_busy", 32'(ctrl_word), 32'h0b);
        wait_busy(1'b0);
        chk("cfg_hold_fall", 32'(ctrl_word), 32'h0b);
        @(negedge clk);
        chk("cfg_hold_idle", 32'(ctrl_word), 32'h0b);
        @(negedge clk);
        chk("cfg_applied", 32'(ctrl_word), 32'h07);
        chk("cfg_no_grant", {31'd0, tx_start}, 32'd0);
        @(negedge clk);
        chk("cfg_then_grant", {31'd0, tx_start}, 32'd1);
        chk("cfg_then_gid", 32'(grant_id), 32'd1);
        chk("cfg_then_data", 32'(tx_data), 32'hC3);
        req_valid = 4'b0000;
        wait_frame_done();

        // lost start: uart never goes busy
        model_on = 1'b0;
        man_busy = 1'b0;
        req_valid = 4'b1000;
        wait_start("lost", ok);
        chk("lost_gid", 32'(grant_id), 32'd3);
        req_valid = 4'b0001;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("lost_c%0d", k), {31'd0, tx_lost}, {31'd0, k == 4});
        end
        @(negedge clk);
        chk("lost_pulse_end", {31'd0, tx_lost}, 32'd0);
        chk("lost_regrant", {31'd0, tx_start}, 32'd1);
        chk("lost_regrant_gid", 32'(grant_id), 32'd0);
        req_valid = 4'b0000;
        repeat (8) @(negedge clk);
        model_on = 1'b1;
        repeat (2) @(negedge clk);

        // reset in the middle of WAIT_DONE
        req_valid = 4'b0100;
        wait_start("rst_pre", ok);
        chk("rst_pre_gid", 32'(grant_id), 32'd2);
        req_valid = 4'b0000;
        wait_busy(1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        reset_values("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst_quiet_start%0d", k), {31'd0, tx_start}, 32'd0);
            chk($sformatf("rst_quiet_lost%0d", k), {31'd0, tx_lost}, 32'd0);
        end
        grant_check("rst_post", 4'b1111, 2'd0, 8'h5A);
        wait_frame_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
